// File: rtl/tc3_pkg.sv
// Shared types and size helpers for the three-way Toom-Cook
// carry-less multiplier.
package tc3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COMB = 2'd2
    } tc3_state_e;

    // Limb length: operands split into three limbs of ceil(width/3) bits.
    function automatic int tc3_limb_len(input int width);
        return (width + 2) / 3;
    endfunction

    // Run cycles: ceil(limb length / digit) steps per operation.
    function automatic int tc3_run_cycles(input int width, input int digit);
        int l;
        l = tc3_limb_len(width);
        return (l + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/tc3_limb_mac.sv
// Digit-serial L x L carry-less limb multiplier: each step folds
// DIGIT bits of the A limb into the 2L-1 bit accumulator.
module tc3_limb_mac
    import tc3_pkg::*;
#(
    parameter int L     = 75,
    parameter int DIGIT = 1,
    parameter int KW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [KW-1:0] k,
    input  logic [L-1:0]  a_limb,
    input  logic [L-1:0]  b_limb,
    output logic [2*L-2:0] acc
);

    localparam int AW = 2 * L - 1;
    localparam logic [L-1:0] LONE = L'(1);

    logic [AW-1:0] b_ext;
    logic [AW-1:0] acc_nxt;

    // XOR in b shifted by each set bit of the current A digit;
    // bits at or beyond L never match the mask and add nothing.
    always_comb begin
        int idx;
        b_ext   = AW'(b_limb);
        acc_nxt = acc;
        for (int j = 0; j < DIGIT; j++) begin
            idx = int'(k) * DIGIT + j;
            if ((a_limb & (LONE << idx)) != '0) begin
                acc_nxt = acc_nxt ^ (b_ext << idx);
            end
        end
    end

    // Accumulator: clear on acceptance, advance one digit per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/three_way_toom_cook_seq.sv
// Sequential three-way split carry-less multiplier: nine limb MACs
// run digit-serially, then one cycle recombines the partials.
module three_way_toom_cook_seq
    import tc3_pkg::*;
#(
    parameter int WIDTH = 224,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);

    localparam int L  = tc3_limb_len(WIDTH);
    localparam int N  = tc3_run_cycles(WIDTH, DIGIT);
    localparam int KW = $clog2(N + 1);
    localparam int PW = 2 * L - 1;
    localparam int EW = 3 * L;
    localparam int FW = 2 * WIDTH;

    tc3_state_e       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    cnt;
    logic [EW-1:0]    a_ext;
    logic [EW-1:0]    b_ext;
    logic [L-1:0]     a_lmb [3];
    logic [L-1:0]     b_lmb [3];
    logic [PW-1:0]    prod  [3][3];
    logic [PW-1:0]    d, e, f, g, h;
    logic [FW-1:0]    full;
    logic             accept;
    logic             step;
    logic             last;

    assign accept = (state == IDLE) && start;
    assign step   = (state == RUN);
    assign last   = (cnt == KW'(N - 1));
    assign a_ext  = EW'(a_q);
    assign b_ext  = EW'(b_q);

    for (genvar gi = 0; gi < 3; gi++) begin : g_limb
        assign a_lmb[gi] = a_ext[gi*L +: L];
        assign b_lmb[gi] = b_ext[gi*L +: L];
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            tc3_limb_mac #(
                .L     (L),
                .DIGIT (DIGIT),
                .KW    (KW)
            ) u_mac (
                .clk    (clk),
                .rst    (rst),
                .clear  (accept),
                .step   (step),
                .k      (cnt),
                .a_limb (a_lmb[gi]),
                .b_limb (b_lmb[gj]),
                .acc    (prod[gi][gj])
            );
        end
    end

    // Group limb products by output weight and fold into the product.
    always_comb begin
        d    = prod[2][2];
        e    = prod[1][2] ^ prod[2][1];
        f    = prod[0][2] ^ prod[1][1] ^ prod[2][0];
        g    = prod[0][1] ^ prod[1][0];
        h    = prod[0][0];
        full = FW'(h)
             ^ (FW'(g) << L)
             ^ (FW'(f) << (2 * L))
             ^ (FW'(e) << (3 * L))
             ^ (FW'(d) << (4 * L));
    end

    // Control FSM: capture, step N digits, register result with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            c     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + KW'(1);
                    if (last) begin
                        state <= COMB;
                    end
                end
                COMB: begin
                    c     <= full;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
